// File: rtl/persp_param_stage_pkg.sv
// persp_param_stage_pkg
//   Shared constants and types for the perspective parameter stage:
//   coefficient widths, the rewind-term multiplier H_MAX and its scan
//   length MUL_BITS, the control FSM encoding and the packed
//   coefficient-set type.
//   Optional macro PERSP_IDENTITY_RESET_EN: when defined, the reset value
//   of the committed set is an identity mapping instead of all zeros.
package persp_param_stage_pkg;

    localparam int P1_W = 68;   // p1, p4
    localparam int P2_W = 69;   // p2, p5
    localparam int P3_W = 79;   // p3, p6
    localparam int P7_W = 59;
    localparam int P8_W = 60;
    localparam int P9_W = 71;
    localparam int DX_W = 79;   // dec_numx_horiz, dec_numy_horiz
    localparam int DD_W = 71;   // dec_denom_horiz

    localparam int H_MAX    = 639;
    localparam int MUL_BITS = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MULT    = 2'd1,
        ST_PENDING = 2'd2
    } state_e;

    typedef struct packed {
        logic signed [P1_W-1:0] p1;
        logic signed [P2_W-1:0] p2;
        logic signed [P3_W-1:0] p3;
        logic signed [P1_W-1:0] p4;
        logic signed [P2_W-1:0] p5;
        logic signed [P3_W-1:0] p6;
        logic signed [P7_W-1:0] p7;
        logic signed [P8_W-1:0] p8;
        logic signed [P9_W-1:0] p9;
    } coef_set_t;

    // Committed-set value after reset. The identity variant keeps the
    // mapper's denominator (p9) non-zero before the first solver result.
    function automatic coef_set_t reset_coefs();
        coef_set_t c;
        c = '0;
`ifdef PERSP_IDENTITY_RESET_EN
        c.p1 = P1_W'(1);
        c.p5 = P2_W'(1);
        c.p9 = P9_W'(1);
`endif
        return c;
    endfunction

`ifdef PERSP_IDENTITY_RESET_EN
    localparam logic signed [DX_W-1:0] RST_NUMX = DX_W'(H_MAX);
`else
    localparam logic signed [DX_W-1:0] RST_NUMX = '0;
`endif

endpackage

// File: rtl/persp_param_stage_if.sv
// persp_param_stage_if
//   Solver-to-stage coefficient handshake: params_valid/params_ready plus
//   the nine signed coefficients p1_in..p9_in.
//   master : solver side (drives valid and coefficients)
//   slave  : persp_param_stage side (drives ready)
interface persp_param_stage_if;
    import persp_param_stage_pkg::*;

    logic                   params_valid;
    logic                   params_ready;
    logic signed [P1_W-1:0] p1_in;
    logic signed [P2_W-1:0] p2_in;
    logic signed [P3_W-1:0] p3_in;
    logic signed [P1_W-1:0] p4_in;
    logic signed [P2_W-1:0] p5_in;
    logic signed [P3_W-1:0] p6_in;
    logic signed [P7_W-1:0] p7_in;
    logic signed [P8_W-1:0] p8_in;
    logic signed [P9_W-1:0] p9_in;

    modport master (
        output params_valid, p1_in, p2_in, p3_in, p4_in, p5_in,
               p6_in, p7_in, p8_in, p9_in,
        input  params_ready
    );

    modport slave (
        input  params_valid, p1_in, p2_in, p3_in, p4_in, p5_in,
               p6_in, p7_in, p8_in, p9_in,
        output params_ready
    );

endinterface

// File: rtl/persp_param_stage_const_mult_seq.sv
// const_mult_seq
//   Sequential shift-add multiply of one signed operand by the constant
//   CONST, scanning one bit of CONST per cycle for NBITS cycles.
//   Ports:
//     clk, rst_n : clock, synchronous active-low reset
//     start      : load operand (sign-extended to OUT_W), clear product
//     operand    : signed multiplicand, sampled when start is high
//     busy       : a bit of CONST is being processed this cycle
//     done       : last bit is being processed this cycle
//     product    : signed CONST*operand, valid once busy drops
module const_mult_seq #(
    parameter int          IN_W  = 68,
    parameter int          OUT_W = 79,
    parameter int unsigned CONST = 639,
    parameter int          NBITS = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [IN_W-1:0]  operand,
    output logic                    busy,
    output logic                    done,
    output logic signed [OUT_W-1:0] product
);

    localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [NBITS-1:0] K = NBITS'(CONST);

    logic                    run_q, run_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [OUT_W-1:0] op_q,  op_d;
    logic signed [OUT_W-1:0] acc_q, acc_d;

    always_comb begin
        run_d = run_q;
        idx_d = idx_q;
        op_d  = op_q;
        acc_d = acc_q;
        if (start) begin
            op_d  = {{(OUT_W-IN_W){operand[IN_W-1]}}, operand};
            acc_d = '0;
            idx_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            if (K[idx_q]) begin
                acc_d = acc_q + (op_q <<< idx_q);
            end
            if (idx_q == IDX_W'(NBITS-1)) begin
                run_d = 1'b0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            idx_q <= '0;
            op_q  <= '0;
            acc_q <= '0;
        end else begin
            run_q <= run_d;
            idx_q <= idx_d;
            op_q  <= op_d;
            acc_q <= acc_d;
        end
    end

    assign busy    = run_q;
    assign done    = run_q && (idx_q == IDX_W'(NBITS-1));
    assign product = acc_q;

endmodule

// File: rtl/persp_param_stage.sv
// persp_param_stage
//   Accepts a set of nine inverse-perspective coefficients from the
//   solver, computes the row-rewind terms H_MAX*p1, H_MAX*p4, H_MAX*p7
//   with three sequential shift-add multipliers, and commits all twelve
//   values to the mapper together on a frame_boundary strobe.
//   Ports:
//     clk, rst_n        : clock, synchronous active-low reset
//     bus (slave)       : params_valid/params_ready + p1_in..p9_in
//     frame_boundary    : mapper is on its last pixel of the frame
//     p1_inv..p9_inv    : committed coefficients
//     dec_*_horiz       : committed rewind terms
//     params_loaded     : one-cycle pulse after a commit
//     pending           : computed set waiting for frame_boundary
//   Macro PERSP_IDENTITY_RESET_EN selects identity reset values.
module persp_param_stage
    import persp_param_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    persp_param_stage_if.slave     bus,
    input  logic                   frame_boundary,
    output logic signed [P1_W-1:0] p1_inv,
    output logic signed [P2_W-1:0] p2_inv,
    output logic signed [P3_W-1:0] p3_inv,
    output logic signed [P1_W-1:0] p4_inv,
    output logic signed [P2_W-1:0] p5_inv,
    output logic signed [P3_W-1:0] p6_inv,
    output logic signed [P7_W-1:0] p7_inv,
    output logic signed [P8_W-1:0] p8_inv,
    output logic signed [P9_W-1:0] p9_inv,
    output logic signed [DX_W-1:0] dec_numx_horiz,
    output logic signed [DX_W-1:0] dec_numy_horiz,
    output logic signed [DD_W-1:0] dec_denom_horiz,
    output logic                   params_loaded,
    output logic                   pending
);

    localparam coef_set_t RST_COEFS = reset_coefs();

    state_e                  state_q, state_d;
    coef_set_t               sh_q, sh_d;       // shadow of the accepted set
    coef_set_t               inv_q, inv_d;     // committed set
    logic signed [DX_W-1:0]  numx_q, numx_d;
    logic signed [DX_W-1:0]  numy_q, numy_d;
    logic signed [DD_W-1:0]  denom_q, denom_d;
    logic                    loaded_q, loaded_d;

    coef_set_t               in_set;
    logic                    start;
    logic [2:0]              mult_busy, mult_done;
    logic signed [DX_W-1:0]  prod_x, prod_y;
    logic signed [DD_W-1:0]  prod_d;

    assign in_set = {bus.p1_in, bus.p2_in, bus.p3_in, bus.p4_in, bus.p5_in,
                     bus.p6_in, bus.p7_in, bus.p8_in, bus.p9_in};

    // Multipliers sample their operand straight off the bus on the accept
    // edge, in step with the shadow capture.
    const_mult_seq #(.IN_W(P1_W), .OUT_W(DX_W), .CONST(H_MAX), .NBITS(MUL_BITS)) u_mult_x (
        .clk(clk), .rst_n(rst_n), .start(start), .operand(bus.p1_in),
        .busy(mult_busy[0]), .done(mult_done[0]), .product(prod_x)
    );
    const_mult_seq #(.IN_W(P1_W), .OUT_W(DX_W), .CONST(H_MAX), .NBITS(MUL_BITS)) u_mult_y (
        .clk(clk), .rst_n(rst_n), .start(start), .operand(bus.p4_in),
        .busy(mult_busy[1]), .done(mult_done[1]), .product(prod_y)
    );
    const_mult_seq #(.IN_W(P7_W), .OUT_W(DD_W), .CONST(H_MAX), .NBITS(MUL_BITS)) u_mult_d (
        .clk(clk), .rst_n(rst_n), .start(start), .operand(bus.p7_in),
        .busy(mult_busy[2]), .done(mult_done[2]), .product(prod_d)
    );

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        inv_d    = inv_q;
        numx_d   = numx_q;
        numy_d   = numy_q;
        denom_d  = denom_q;
        loaded_d = 1'b0;
        start    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.params_valid) begin
                    sh_d    = in_set;
                    start   = 1'b1;
                    state_d = ST_MULT;
                end
            end
            ST_MULT: begin
                // A strobe here is deliberately ignored; the set is not
                // complete until the last bit has been accumulated.
                if ((&mult_done) || !(|mult_busy)) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (frame_boundary) begin
                    inv_d    = sh_q;
                    numx_d   = prod_x;
                    numy_d   = prod_y;
                    denom_d  = prod_d;
                    loaded_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sh_q     <= '0;
            inv_q    <= RST_COEFS;
            numx_q   <= RST_NUMX;
            numy_q   <= '0;
            denom_q  <= '0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            inv_q    <= inv_d;
            numx_q   <= numx_d;
            numy_q   <= numy_d;
            denom_q  <= denom_d;
            loaded_q <= loaded_d;
        end
    end

    assign bus.params_ready = (state_q == ST_IDLE);
    assign pending          = (state_q == ST_PENDING);
    assign params_loaded    = loaded_q;

    assign p1_inv          = inv_q.p1;
    assign p2_inv          = inv_q.p2;
    assign p3_inv          = inv_q.p3;
    assign p4_inv          = inv_q.p4;
    assign p5_inv          = inv_q.p5;
    assign p6_inv          = inv_q.p6;
    assign p7_inv          = inv_q.p7;
    assign p8_inv          = inv_q.p8;
    assign p9_inv          = inv_q.p9;
    assign dec_numx_horiz  = numx_q;
    assign dec_numy_horiz  = numy_q;
    assign dec_denom_horiz = denom_q;

endmodule

// File: tb/tb_persp_param_stage.sv
module tb_persp_param_stage;
    import persp_param_stage_pkg::*;

    localparam int HM = 639;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_boundary = 1'b0;

    logic signed [67:0] p1_inv, p4_inv;
    logic signed [68:0] p2_inv, p5_inv;
    logic signed [78:0] p3_inv, p6_inv;
    logic signed [58:0] p7_inv;
    logic signed [59:0] p8_inv;
    logic signed [70:0] p9_inv;
    logic signed [78:0] dec_numx_horiz, dec_numy_horiz;
    logic signed [70:0] dec_denom_horiz;
    logic               params_loaded, pending;

    persp_param_stage_if bus();

    persp_param_stage dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .frame_boundary(frame_boundary),
        .p1_inv(p1_inv), .p2_inv(p2_inv), .p3_inv(p3_inv), .p4_inv(p4_inv),
        .p5_inv(p5_inv), .p6_inv(p6_inv), .p7_inv(p7_inv), .p8_inv(p8_inv),
        .p9_inv(p9_inv), .dec_numx_horiz(dec_numx_horiz),
        .dec_numy_horiz(dec_numy_horiz), .dec_denom_horiz(dec_denom_horiz),
        .params_loaded(params_loaded), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [67:0] p1;
        logic signed [68:0] p2;
        logic signed [78:0] p3;
        logic signed [67:0] p4;
        logic signed [68:0] p5;
        logic signed [78:0] p6;
        logic signed [58:0] p7;
        logic signed [59:0] p8;
        logic signed [70:0] p9;
        logic signed [78:0] dx;
        logic signed [78:0] dy;
        logic signed [70:0] dd;
    } vec_t;

    int   n_vec = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   rst_seen = 1'b0;
    bit   armed = 1'b0;
    vec_t sb[$];
    vec_t cur;

    task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain full-precision products, truncated to the output width.
    function automatic vec_t with_products(input vec_t s);
        logic signed [78:0] a, b, h;
        logic signed [70:0] c, h2;
        a = s.p1; b = s.p4; c = s.p7;
        h = 79'(HM); h2 = 71'(HM);
        s.dx = a * h;
        s.dy = b * h;
        s.dd = c * h2;
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic vec_t rand_vec();
        vec_t s;
        logic [127:0] r;
        r = rnd128(); s.p1 = r[67:0];
        r = rnd128(); s.p2 = r[68:0];
        r = rnd128(); s.p3 = r[78:0];
        r = rnd128(); s.p4 = r[67:0];
        r = rnd128(); s.p5 = r[68:0];
        r = rnd128(); s.p6 = r[78:0];
        r = rnd128(); s.p7 = r[58:0];
        r = rnd128(); s.p8 = r[59:0];
        r = rnd128(); s.p9 = r[70:0];
        return with_products(s);
    endfunction

    function automatic vec_t reset_vec();
        vec_t s;
        s.p1 = '0; s.p2 = '0; s.p3 = '0; s.p4 = '0; s.p5 = '0; s.p6 = '0;
        s.p7 = '0; s.p8 = '0; s.p9 = '0; s.dx = '0; s.dy = '0; s.dd = '0;
`ifdef PERSP_IDENTITY_RESET_EN
        s.p1 = 68'sd1; s.p5 = 69'sd1; s.p9 = 71'sd1; s.dx = 79'sd639;
`endif
        return s;
    endfunction

    task automatic cmp_outputs(input bit detail);
        if (detail) begin
            chk("p1_inv", p1_inv, cur.p1);
            chk("p2_inv", p2_inv, cur.p2);
            chk("p3_inv", p3_inv, cur.p3);
            chk("p4_inv", p4_inv, cur.p4);
            chk("p5_inv", p5_inv, cur.p5);
            chk("p6_inv", p6_inv, cur.p6);
            chk("p7_inv", p7_inv, cur.p7);
            chk("p8_inv", p8_inv, cur.p8);
            chk("p9_inv", p9_inv, cur.p9);
            chk("dec_numx", dec_numx_horiz, cur.dx);
            chk("dec_numy", dec_numy_horiz, cur.dy);
            chk("dec_denom", dec_denom_horiz, cur.dd);
        end else begin
            chk("outputs_hold",
                {p1_inv, p2_inv, p3_inv, p4_inv, p5_inv, p6_inv, p7_inv, p8_inv, p9_inv,
                 dec_numx_horiz, dec_numy_horiz, dec_denom_horiz},
                {cur.p1, cur.p2, cur.p3, cur.p4, cur.p5, cur.p6, cur.p7, cur.p8, cur.p9,
                 cur.dx, cur.dy, cur.dd});
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        rst_seen = !rst_n;
    end

    // Monitor: pops the expected set whenever the DUT signals a commit and
    // otherwise checks that the committed outputs hold.
    initial forever begin
        @(negedge clk);
        if (rst_seen) begin
            armed = 1'b1;
            cur = reset_vec();
            sb.delete();
            chk("rst_no_loaded", params_loaded, 1'b0);
            cmp_outputs(1'b1);
        end else if (armed) begin
            if (params_loaded) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL spurious_load: got params_loaded=1 expected no commit");
                end else begin
                    cur = sb.pop_front();
                end
                cmp_outputs(1'b1);
            end else begin
                cmp_outputs(1'b0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic drive(input vec_t s);
        bus.p1_in = s.p1; bus.p2_in = s.p2; bus.p3_in = s.p3;
        bus.p4_in = s.p4; bus.p5_in = s.p5; bus.p6_in = s.p6;
        bus.p7_in = s.p7; bus.p8_in = s.p8; bus.p9_in = s.p9;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic accept(input vec_t s, input bit keep_valid, output int acc_cyc);
        int w;
        drive(s);
        bus.params_valid = 1'b1;
        w = 0;
        while (!bus.params_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) chk("accept_timeout", 1'b0, 1'b1);
        @(posedge clk);
        sb.push_back(s);
        @(negedge clk);
        acc_cyc = cyc;
        if (!keep_valid) bus.params_valid = 1'b0;
    endtask

    task automatic wait_pending();
        int w;
        w = 0;
        while (!pending && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) chk("pending_timeout", 1'b0, 1'b1);
    endtask

    task automatic commit();
        frame_boundary = 1'b1;
        @(negedge clk);
        frame_boundary = 1'b0;
        chk("loaded_pulse", params_loaded, 1'b1);
        chk("ready_after_commit", bus.params_ready, 1'b1);
        @(negedge clk);
        chk("loaded_once", params_loaded, 1'b0);
    endtask

    initial begin
        vec_t s;
        int   a;
        logic signed [78:0] ex_dx;
        logic signed [70:0] ex_dd;

        bus.params_valid = 1'b0;
        drive(reset_vec());
        rst_n = 1'b0;

        // Reset
        repeat (2) @(negedge clk);
        chk("rst_ready", bus.params_ready, 1'b1);
        chk("rst_pending", pending, 1'b0);
        chk("rst_p1", p1_inv, reset_vec().p1);
        chk("rst_p9", p9_inv, reset_vec().p9);
        chk("rst_numx", dec_numx_horiz, reset_vec().dx);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic load with latency
        s = rand_vec();
        s.p1 = 68'sd3; s.p4 = -68'sd2; s.p7 = 59'sd5;
        s = with_products(s);
        accept(s, 1'b0, a);
        wait_pending();
        chk("pending_latency", cyc - a, 10);
        commit();
        chk("basic_numx", dec_numx_horiz, 1917);
        chk("basic_numy", dec_numy_horiz, -1278);
        chk("basic_denom", dec_denom_horiz, 3195);

        // Hold until boundary
        s = rand_vec();
        accept(s, 1'b0, a);
        wait_pending();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            chk("hold_pending", pending, 1'b1);
            chk("hold_no_load", params_loaded, 1'b0);
        end
        commit();

        // Extremes
        s = rand_vec();
        s.p1 = {1'b1, {67{1'b0}}};
        s.p7 = {1'b0, {58{1'b1}}};
        s = with_products(s);
        accept(s, 1'b0, a);
        wait_pending();
        commit();
        ex_dx = -(79'sd639 * (79'sd1 <<< 67));
        ex_dd = 71'sd639 * ((71'sd1 <<< 58) - 71'sd1);
        chk("ext_numx", dec_numx_horiz, ex_dx);
        chk("ext_denom", dec_denom_horiz, ex_dd);

        // Backpressure with changing p1_in, strobe on the last MULT cycle
        s = rand_vec();
        accept(s, 1'b1, a);
        while (cyc < a + 9) begin
            bus.p1_in = rnd128() >> 60;
            @(negedge clk);
        end
        frame_boundary = 1'b1;
        @(negedge clk);
        frame_boundary = 1'b0;
        chk("late_strobe_pending", pending, 1'b1);
        chk("late_strobe_no_load", params_loaded, 1'b0);
        @(negedge clk);
        chk("late_strobe_no_load2", params_loaded, 1'b0);
        chk("busy_not_ready", bus.params_ready, 1'b0);
        bus.params_valid = 1'b0;
        commit();

        // Mid-MULT reset
        s = rand_vec();
        accept(s, 1'b0, a);
        while (cyc < a + 5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_ready", bus.params_ready, 1'b1);
        chk("midrst_pending", pending, 1'b0);
        chk("midrst_numx", dec_numx_horiz, reset_vec().dx);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("midrst_no_load", params_loaded, 1'b0);
            chk("midrst_idle", pending, 1'b0);
        end

        // Random sets, stray strobes during MULT, random boundary delays
        for (int n = 0; n < 10; n++) begin
            int k, d;
            s = rand_vec();
            accept(s, 1'b0, a);
            k = $urandom_range(0, 8);
            while (cyc < a + k) @(negedge clk);
            frame_boundary = 1'b1;
            @(negedge clk);
            frame_boundary = 1'b0;
            wait_pending();
            d = $urandom_range(0, 15);
            for (int i = 0; i < d; i++) begin
                @(negedge clk);
                chk("rand_wait_pending", pending, 1'b1);
            end
            commit();
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/persp_param_stage.md
Name: persp_param_stage

Overview:
- Sits directly upstream of the perspective pixel mapper.
- Accepts a fresh set of nine inverse-perspective coefficients p1..p9 from the parameter solver through a valid/ready handshake.
- Computes the end-of-row rewind terms H_MAX*p1, H_MAX*p4 and H_MAX*p7 with a multi-cycle shift-add. These are the terms the mapper subtracts when it wraps a row.
- Presents all twelve values to the mapper as a coherent set, committed only at a frame boundary, so no frame ever uses mixed coefficients.

Parameters:
- H_MAX, 639, last column index of the output raster; constant multiplier for the rewind terms.
- MUL_BITS, 10, number of bits of H_MAX scanned by the shift-add; one bit per cycle.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- params_valid  in  1  solver has a coefficient set on p*_in
- params_ready  out  1  block can accept a set this cycle
- p1_in,p4_in  in  68 each  signed
- p2_in,p5_in  in  69 each  signed
- p3_in,p6_in  in  79 each  signed
- p7_in  in  59  signed
- p8_in  in  60  signed
- p9_in  in  71  signed
- frame_boundary  in  1  one-cycle strobe from the mapper's pixel sequencer while it is on its last pixel (x=H_MAX, y=last row)
- p1_inv..p9_inv  out  widths as p1_in..p9_in  committed coefficients
- dec_numx_horiz  out  79  signed, H_MAX*p1_inv
- dec_numy_horiz  out  79  signed, H_MAX*p4_inv
- dec_denom_horiz  out  71  signed, H_MAX*p7_inv
- params_loaded  out  1  one-cycle pulse in the cycle after a commit
- pending  out  1  a computed set is waiting for frame_boundary

Behaviour:
- States: IDLE, MULT, PENDING.
- Reset (rst_n=0 at a clk edge, in any state, including mid-MULT):
  - state=IDLE; all p*_inv and dec_* = 0.
  - params_loaded=0, pending=0.
  - Shadow registers and accumulators cleared.
- params_ready = (state==IDLE), combinational from state.
- IDLE:
  - On params_valid & params_ready, capture p1_in..p9_in into shadow registers.
  - Clear the three accumulators, bit index i=0, go to MULT.
  - Committed outputs are untouched.
- MULT, one cycle per bit i = 0..MUL_BITS-1:
  - If H_MAX[i]: acc_x += sext(sh_p1)<<i; acc_y += sext(sh_p4)<<i; acc_d += sext(sh_p7)<<i.
  - Sign-extend to 79/79/71 bits before shifting; arithmetic is two's complement.
  - Widths are sized so that no overflow can occur for H_MAX < 2^MUL_BITS.
  - After the i=MUL_BITS-1 cycle, go to PENDING. Exactly MUL_BITS cycles are spent in MULT.
- PENDING:
  - pending=1.
  - On frame_boundary: copy shadow p1..p9 to p*_inv and acc_x/acc_y/acc_d to dec_*. These outputs change on that clk edge.
  - Then go to IDLE; params_loaded=1 for exactly the next cycle.
- frame_boundary in IDLE or MULT: ignored, committed outputs hold. A strobe in the same cycle as the final MULT bit is also ignored; commit waits for the next strobe.
- params_valid while not ready: not captured. The solver must hold the set until ready.
- All twelve outputs always change together, on one clock edge.
- Minimum accept-to-commit latency: 1 (capture) + MUL_BITS + 1 cycles, given frame_boundary on the first PENDING cycle.

Optional Feature:
- Macro: PERSP_IDENTITY_RESET_EN.
- When defined, reset loads an identity mapping instead of zeros:
  - p1_inv=1, p5_inv=1, p9_inv=1; all other p*_inv=0.
  - dec_numx_horiz=H_MAX; dec_numy_horiz=0; dec_denom_horiz=0.
  - The mapper therefore never divides by zero before the first solver result arrives.
- When undefined, all outputs reset to 0.

Decomposition:
- Shared package: coefficient width constants (68/69/79/59/60/71), H_MAX, MUL_BITS, state encoding.
- One natural sub-module: const_mult_seq, a single-operand shift-add multiplier by a constant. Ports: start, operand, busy, done, product. Instantiated three times with output widths 79/79/71.

Test Plan:
- Reset default: rst_n low 2 cycles -> all outputs 0, params_ready=1. With PERSP_IDENTITY_RESET_EN defined: p1_inv=p5_inv=p9_inv=1, dec_numx_horiz=639.
- Basic load: p1=3, p4=-2, p7=5, others arbitrary, frame_boundary high on the first PENDING cycle -> commit 12 cycles after acceptance: dec_numx=1917, dec_numy=-1278, dec_denom=3195; params_loaded pulses once.
- Hold-until-boundary: load a set, delay frame_boundary 500 cycles -> outputs keep their old values and pending=1 throughout; all twelve outputs update on the same edge as the strobe.
- Extremes: p1 = -2^67, p7 = 2^58-1 -> dec_numx = -639*2^67 and dec_denom = 639*(2^58-1) exactly, with no wrap.
- Backpressure and early strobe: params_valid held through MULT/PENDING with a changing p1_in -> only the value present at acceptance is used. A frame_boundary on the last MULT cycle does not commit.
- Mid-operation reset: assert rst_n low on MULT cycle 5 -> IDLE next cycle, outputs at reset values, no params_loaded pulse.
